// File: rtl/axi4lite_pkg.sv
// FSM encoding and AXI4-Lite response/protection constants shared by the
// command-driven AXI4-Lite master.
package axi4lite_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RSP   = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4lite_wdog.sv
// Saturating transaction watchdog: cleared on command accept, counts while a
// bus transaction is outstanding, never wraps.
module axi4lite_wdog #(
  parameter  int LIMIT = 1024,
  localparam int CW    = $clog2(LIMIT + 1)
) (
  input  logic m_axi_aclk,
  input  logic m_axi_areset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] cnt;

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset || clr) cnt <= '0;
    else if (en && cnt != CW'(LIMIT)) cnt <= cnt + CW'(1);
  end

  // High in the cycle whose increment reaches LIMIT, and stays high once saturated.
  assign expired = en && (cnt >= CW'(LIMIT - 1));

endmodule

// File: rtl/axi4lite_master_cmd.sv
// AXI4-Lite master fed by a valid/ready command port; one transaction in
// flight, response (or timeout) returned on a valid/ready response port.
module axi4lite_master_cmd
  import axi4lite_pkg::*;
#(
  parameter  int ADDR_WIDTH     = 32,
  parameter  int DATA_WIDTH     = 32,  // 32 or 64
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  state_t state;
  logic   accept, active, expired, advance, tmo, aw_left, w_left;

  assign cmd_ready    = (state == IDLE) && !m_axi_areset;
  assign accept       = cmd_valid && cmd_ready;
  assign busy         = (state != IDLE);
  assign active       = (state == WADDR) || (state == WRESP) ||
                        (state == RADDR) || (state == RDATA);
  assign M_AXI_AWPROT = PROT_DEFAULT;
  assign M_AXI_ARPROT = PROT_DEFAULT;

  assign aw_left = M_AXI_AWVALID && !M_AXI_AWREADY;
  assign w_left  = M_AXI_WVALID && !M_AXI_WREADY;

  // A phase-completing handshake in the expiry cycle beats the timeout.
  always_comb begin
    advance = 1'b0;
    case (state)
      WADDR:   advance = !aw_left && !w_left;
      WRESP:   advance = M_AXI_BVALID;
      RADDR:   advance = M_AXI_ARREADY;
      RDATA:   advance = M_AXI_RVALID;
      default: advance = 1'b0;
    endcase
  end
  assign tmo = expired && !advance;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      axi4lite_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
        .m_axi_aclk   (m_axi_aclk),
        .m_axi_areset (m_axi_areset),
        .clr          (accept),
        .en           (active),
        .expired      (expired)
      );
    end else begin : g_no_wdog
      assign expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state         <= IDLE;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
      rsp_timeout   <= 1'b0;
    end else if (tmo) begin
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b1;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_SLVERR;
      rsp_timeout   <= 1'b1;
      state         <= RSP;
    end else begin
      case (state)
        IDLE: if (accept) begin
          rsp_write <= cmd_write;
          if (cmd_write) begin
            M_AXI_AWADDR  <= cmd_addr;
            M_AXI_WDATA   <= cmd_wdata;
            M_AXI_WSTRB   <= cmd_wstrb;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            state         <= WADDR;
          end else begin
            M_AXI_ARADDR  <= cmd_addr;
            M_AXI_ARVALID <= 1'b1;
            state         <= RADDR;
          end
        end
        WADDR: begin
          // Each VALID drops right after its own handshake.
          M_AXI_AWVALID <= aw_left;
          M_AXI_WVALID  <= w_left;
          if (advance) begin
            M_AXI_BREADY <= 1'b1;
            state        <= WRESP;
          end
        end
        WRESP: if (M_AXI_BVALID) begin
          M_AXI_BREADY <= 1'b0;
          rsp_valid    <= 1'b1;
          rsp_rdata    <= '0;
          rsp_resp     <= M_AXI_BRESP;
          rsp_timeout  <= 1'b0;
          state        <= RSP;
        end
        RADDR: if (M_AXI_ARREADY) begin
          M_AXI_ARVALID <= 1'b0;
          M_AXI_RREADY  <= 1'b1;
          state         <= RDATA;
        end
        RDATA: if (M_AXI_RVALID) begin
          M_AXI_RREADY <= 1'b0;
          rsp_valid    <= 1'b1;
          rsp_rdata    <= M_AXI_RDATA;
          rsp_resp     <= M_AXI_RRESP;
          rsp_timeout  <= 1'b0;
          state        <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
